// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word accesses into 32-bit little-endian word
// accesses on a combinational-read data memory, using read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] byte_addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_MW,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, ERR} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sign_ext_q, sign_ext_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         word_q, word_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                misalign_q, misalign_d;

    logic                illegal;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [31:0]         load_val;
    logic [31:0]         merge_val;

    always_comb begin
        case (size)
            2'b11:   illegal = 1'b1;
            2'b01:   illegal = byte_addr[0];
            2'b10:   illegal = |byte_addr[1:0];
            default: illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = illegal ? ERR : ACCESS;
            ACCESS:  state_d = we_q ? WRITE : IDLE;
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write enable is decoded from state so reset removes it without waiting for an edge.
    always_comb begin
        busy   = (state_q != IDLE);
        mem_MW = (state_q == WRITE);
    end

    always_comb begin
        lane_b   = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = mem_data_out[{addr_q[1], 4'b0000} +: 16];
        load_val = mem_data_out;
        case (size_q)
            2'b00:   load_val = {{24{sign_ext_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{sign_ext_q & lane_h[15]}}, lane_h};
            default: load_val = mem_data_out;
        endcase
    end

    always_comb begin
        merge_val = word_q;
        case (size_q)
            2'b00:   merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merge_val = wdata_q;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    addr_d     = byte_addr;
                    wdata_d    = wdata;
                end
            end
            ACCESS: begin
                word_d = mem_data_out;
                if (!we_q) begin
                    rdata_d = load_val;
                    done_d  = 1'b1;
                end
            end
            WRITE: done_d = 1'b1;
            ERR: begin
                done_d     = 1'b1;
                misalign_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            rdata_q    <= 32'h0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            size_q     <= size_d;
            sign_ext_q <= sign_ext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    assign done        = done_q;
    assign misalign    = misalign_q;
    assign rdata       = rdata_q;
    assign mem_addr    = addr_q[ADDR_W-1:2];
    assign mem_data_in = merge_val;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute/memory stage and the word-addressed data memory; feeds that memory's addr/MW/data_in and consumes its combinational data_out.
- Converts CPU byte-addressed byte/halfword/word loads and stores into 32-bit word accesses, little-endian.
- Sub-word stores use read-modify-write.
- Loads support sign or zero extension; misaligned or reserved-size requests are rejected without touching memory.

Parameters:
- ADDR_W, 16, CPU byte-address width; word address is ADDR_W-2 bits (14 at default).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request strobe, sampled only in IDLE
- we  input  1  1=store, 0=load
- size  input  2  00=byte, 01=halfword, 10=word, 11=reserved
- sign_ext  input  1  loads: 1=sign-extend, 0=zero-extend
- byte_addr  input  ADDR_W  CPU byte address
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- misalign  output  1  high only together with done when the request was rejected
- rdata  output  32  extended load result
- mem_addr  output  ADDR_W-2  word address to the data memory
- mem_MW  output  1  memory write enable
- mem_data_in  output  32  word to write
- mem_data_out  input  32  combinational read word from the memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, misalign, mem_MW = 0.
  - rdata=0, mem_addr=0, all latched request fields = 0.
  - mem_MW is decoded from state, so it drops immediately on reset assertion.
- States: IDLE, ACCESS, WRITE, ERR.
- IDLE: on an edge with req=1, latch we, size, sign_ext, byte_addr, wdata.
  - Illegal request goes to ERR: size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - Otherwise go to ACCESS.
  - req=0: stay in IDLE.
- ERR: lasts one cycle, then IDLE; done=1 and misalign=1 in the following cycle. No memory write; rdata unchanged.
- ACCESS:
  - mem_addr = latched byte_addr[ADDR_W-1:2]; mem_MW=0.
  - At the edge, capture mem_data_out into word_q.
  - Load: rdata <= extracted/extended lane; go to IDLE with done=1 next cycle.
  - Store: go to WRITE.
- Lane selection for loads:
  - Byte at offset k: bits [8k+7:8k].
  - Half at offset 0: [15:0]; at offset 2: [31:16].
  - Sign extension uses the lane MSB.
- WRITE:
  - mem_MW=1 for exactly this one cycle; mem_data_in = word_q with the addressed lane replaced by wdata's low bits. A word store replaces all 32 bits.
  - At the edge, go to IDLE with done=1 next cycle.
- Latency, counting the accepting edge as edge 0 (done is high in the cycle after the edge shown):
  - Load: done after edge 1.
  - Store: done after edge 2.
  - Reject: done after edge 1.
- done and misalign are registered, each high for exactly one cycle. done never rises without a completed or rejected request.
- Back-to-back operation: the done cycle is IDLE, so a req present in that cycle is accepted at its closing edge.
- req while busy is ignored; latched fields are held for the whole operation.
- rdata holds its value until the next successful load; stores and rejects do not modify it.
- mem_data_in outside WRITE holds the merge value and is don't-care.
- mem_addr holds its last value when idle.
- Reset mid-operation: abort immediately to IDLE. A write whose edge has not occurred is not performed.

Test Plan:
1. Store word 0xDEADBEEF at byte_addr 0x0014 → mem_MW high exactly one cycle with mem_addr=5, mem_data_in=0xDEADBEEF, done after edge 2. Then load word 0x0014 → rdata=0xDEADBEEF, done after edge 1, misalign=0.
2. Preload word 6 = 0x11223344; store byte wdata=0x000000A5 at 0x0019 → mem_data_in=0x1122A544. Load byte 0x0019 with sign_ext=1 → 0xFFFFFFA5; with sign_ext=0 → 0x000000A5.
3. Word 10 = 0; store halfword 0x8001 at 0x002A → word 10 = 0x80010000. Load half at 0x002A: signed → 0xFFFF8001; load half at 0x0028 → 0x00000000.
4. Word load at 0x0013, half load at 0x0015, size=11 at 0x0000 → each gives done=misalign=1 for one cycle after edge 1; mem_MW never high; rdata unchanged.
5. Store byte in progress; drop rst_n during WRITE → mem_MW=0 combinationally, busy=0, done=0, rdata=0; target memory word unchanged.
6. Pulse req again while busy → ignored, single done. Issue a new load req in the done cycle of a previous store → accepted, second done after one further cycle.
